// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops words from a first-word-fall-through FIFO and sends each
//               one as a UART frame: one start bit, DBIT data bits LSB first,
//               and SB_TICK oversample ticks of stop time. Includes its own
//               16x oversample tick divider.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);

    localparam int                  NB_W      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [DVSR_BIT-1:0] DIV_LAST  = DVSR_BIT'(DVSR - 1);
    localparam logic [4:0]          TICK_LAST = 5'd15;
    localparam logic [4:0]          STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NB_W-1:0]     BIT_LAST  = NB_W'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DVSR_BIT-1:0] div_q,   div_d;
    logic [4:0]          tick_q,  tick_d;
    logic [NB_W-1:0]     bit_q,   bit_d;
    logic [DBIT-1:0]     shift_q, shift_d;
    logic                tx_q,    tx_d;
    logic                s_tick;

    // State and datapath registers; reset aborts any frame and parks tx high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Oversample tick: one clock out of every DVSR
    always_comb begin
        s_tick = (div_q == DIV_LAST);
    end

    // Next-state logic, FIFO pop strobe, done pulse and next tx level
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        div_d        = s_tick ? '0 : div_q + 1'b1;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;

        case (state_q)
            IDLE: begin
                // Gating with reset keeps the pop strobe quiet while held in reset
                if (!fifo_empty && !reset) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_r_data;
                    tick_d  = '0;
                    // Restart the divider so the start bit is exactly 16 ticks
                    div_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so it is derived from where the FSM is heading
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx. Two instances (1 and 2
//               stop bits) are fed from bench-side FIFOs and compared every
//               cycle against a frame-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DVSR   = 4;
    localparam int DBIT   = 8;
    localparam int BITC   = 16 * DVSR;
    localparam int FRAME0 = (16 * (DBIT + 1) + 16) * DVSR;
    localparam int FRAME1 = (16 * (DBIT + 1) + 32) * DVSR;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] w_empty;
    logic [1:0] w_rd;
    logic [1:0] w_tx;
    logic [1:0] w_busy;
    logic [1:0] w_done;
    logic [7:0] w_data [2];

    // Bench-side FIFO storage, one per instance
    logic [7:0] mem [2][256];
    int         head [2] = '{0, 0};
    int         tail [2] = '{0, 0};
    logic [1:0] pop_pending = 2'b00;

    // Reference model state
    logic       frame_on  [2] = '{1'b0, 1'b0};
    int         frame_t   [2] = '{0, 0};
    logic [7:0] frame_w   [2];
    int         free_at   [2] = '{0, 0};
    int         frame_len [2] = '{FRAME0, FRAME1};

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic m_tx, m_busy, m_rd, m_done;
    int   m_k;

    assign w_empty[0] = (head[0] == tail[0]);
    assign w_empty[1] = (head[1] == tail[1]);
    assign w_data[0]  = mem[0][head[0] % 256];
    assign w_data[1]  = mem[1][head[1] % 256];

    fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR), .DVSR_BIT(8)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (w_empty[0]),
        .fifo_r_data  (w_data[0]),
        .fifo_rd      (w_rd[0]),
        .tx           (w_tx[0]),
        .busy         (w_busy[0]),
        .tx_done_tick (w_done[0])
    );

    fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(32), .DVSR(DVSR), .DVSR_BIT(8)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (w_empty[1]),
        .fifo_r_data  (w_data[1]),
        .fifo_rd      (w_rd[1]),
        .tx           (w_tx[1]),
        .busy         (w_busy[1]),
        .tx_done_tick (w_done[1])
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int u, input logic [7:0] d);
        mem[u][tail[u] % 256] = d;
        tail[u]++;
    endtask

    task automatic wait_quiet(input int maxc);
        int n;
        n = 0;
        while (!(head[0] == tail[0] && head[1] == tail[1] &&
                 cyc >= free_at[0] && cyc >= free_at[1]) && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= maxc) check_val("timeout_quiet", 32'd0, 32'd1);
    endtask

    // Cycle counter and FIFO pop applied just after the clock edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        for (int u = 0; u < 2; u++) begin
            if (pop_pending[u]) head[u]++;
        end
    end

    // Reference model: a pop happens when the FIFO holds data and the previous
    // frame has fully elapsed; tx follows start/data/stop timing from that pop
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_tx = 1'b1; m_busy = 1'b0; m_rd = 1'b0; m_done = 1'b0;
            if (reset) begin
                frame_on[u] = 1'b0;
                free_at[u]  = 0;
            end else begin
                if (frame_on[u] && cyc > frame_t[u] && cyc <= frame_t[u] + frame_len[u]) begin
                    m_k    = cyc - frame_t[u] - 1;
                    m_busy = 1'b1;
                    if (m_k < BITC) m_tx = 1'b0;
                    else if (m_k < BITC * (DBIT + 1)) m_tx = frame_w[u][(m_k - BITC) / BITC];
                    m_done = (cyc == frame_t[u] + frame_len[u]);
                end
                m_rd = (head[u] != tail[u]) && (cyc >= free_at[u]);
                if (m_rd) begin
                    frame_on[u] = 1'b1;
                    frame_t[u]  = cyc;
                    frame_w[u]  = mem[u][head[u] % 256];
                    free_at[u]  = cyc + frame_len[u] + 1;
                end
            end
            check_val($sformatf("tx_u%0d", u),   w_tx[u],   m_tx);
            check_val($sformatf("busy_u%0d", u), w_busy[u], m_busy);
            check_val($sformatf("rd_u%0d", u),   w_rd[u],   m_rd);
            check_val($sformatf("done_u%0d", u), w_done[u], m_done);
            pop_pending[u] = w_rd[u];
        end
    end

    initial begin
        int target;
        int n;
        int u;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tx",   w_tx[0],   1'b1);
        check_val("rst_busy", w_busy[0], 1'b0);
        check_val("rst_rd",   w_rd[0],   1'b0);
        check_val("rst_done", w_done[0], 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Long idle with empty FIFOs
        repeat (2000) @(posedge clk);
        #1;
        check_val("idle_no_pop", head[0] + head[1], 32'd0);

        // Single words: 0xA5 on 1-stop instance, 0x81 on 2-stop instance
        push(0, 8'hA5);
        push(1, 8'h81);
        wait_quiet(3000);

        // Back-to-back frames
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_quiet(3000);

        // FIFO refilled while a frame is in flight
        push(0, 8'($urandom));
        repeat (200) @(posedge clk);
        #1;
        push(0, 8'($urandom));
        push(1, 8'($urandom));
        repeat (300) @(posedge clk);
        #1;
        push(0, 8'($urandom));
        push(1, 8'($urandom));
        wait_quiet(5000);

        // Randomized traffic with random gaps
        for (int i = 0; i < 10; i++) begin
            u = int'($urandom_range(0, 1));
            push(u, 8'($urandom));
            repeat ($urandom_range(0, 900)) @(posedge clk);
            #1;
        end
        wait_quiet(12000);

        // Reset in the middle of data bit 3; aborted word must not reappear
        push(0, 8'hC3);
        n = 0;
        while (head[0] != tail[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check_val("timeout_pop", 32'd0, 32'd1);
        target = frame_t[0] + BITC + 3 * BITC + 10;
        n = 0;
        while (cyc < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        #1;
        check_val("abort_tx",   w_tx[0],   1'b1);
        check_val("abort_busy", w_busy[0], 1'b0);
        push(0, 8'h3C);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        wait_quiet(3000);
        check_val("all_popped_u0", head[0], tail[0]);
        check_val("all_popped_u1", head[1], tail[1]);

        repeat (20) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Reader-side consumer for the team's FIFO. Pops words from a first-word-fall-through FIFO and serializes each word as an asynchronous UART frame: 1 start bit, DBIT data bits LSB-first, stop time of SB_TICK oversample ticks.
- Contains its own 16x oversample tick generator.
- Sits between the FIFO read port and the board-level TX pin.

Parameters:
- DBIT, 8: data bits per frame; must equal the FIFO word width.
- SB_TICK, 16: stop duration in oversample ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- DVSR, 163: clocks per oversample tick. Bit time = 16*DVSR clocks.
- DVSR_BIT, 8: width of the tick divider counter; must satisfy 2^DVSR_BIT >= DVSR.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_r_data  in  DBIT  FIFO head word; valid whenever fifo_empty=0
- fifo_rd  out  1  FIFO pop strobe, one clock wide
- tx  out  1  serial output, idle high
- busy  out  1  high while a frame is in progress
- tx_done_tick  out  1  one-clock pulse at end of stop time

Behaviour:
- Reset, asynchronous:
  - state = IDLE; tx = 1; busy = 0; tx_done_tick = 0; fifo_rd = 0.
  - Tick divider, tick count and bit count all cleared.
  - Reset mid-frame aborts the frame. tx returns high immediately and the popped word is discarded.
- Tick generator:
  - Divider counts 0..DVSR-1. s_tick = 1 when the divider equals DVSR-1.
  - Divider is forced to 0 on the IDLE->START transition, so every frame's bit timing is exact.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx = 1, busy = 0. When fifo_empty = 0:
    - fifo_rd = 1 combinationally in that same cycle.
    - fifo_r_data is captured into the shift register at that clock edge.
    - Tick count is cleared and the FSM goes to START.
    - fifo_rd is never asserted when fifo_empty = 1, so the FIFO cannot underflow.
  - START: tx = 0. On each s_tick, tick count increments. At tick 15, tick count clears, bit count clears, and the FSM goes to DATA.
  - DATA: tx = shift_reg[0]. At tick 15:
    - Shift register shifts right one place and tick count clears.
    - If bit count = DBIT-1, go to STOP; otherwise bit count increments.
  - STOP: tx = 1. At tick SB_TICK-1, tx_done_tick = 1 for that one clock and the FSM goes to IDLE.
- Timing:
  - tx is registered. If fifo_rd is asserted in cycle T, tx first goes low in cycle T+1.
  - START, DATA and STOP occupy (16*(DBIT+1) + SB_TICK)*DVSR consecutive clocks.
  - The FSM is back in IDLE in the following cycle, and the next pop can occur in that cycle.
  - Back-to-back frames therefore have exactly one extra idle-high clock between them.
- busy = 1 in START, DATA and STOP; 0 in IDLE.
- fifo_rd and tx_done_tick are never high in the same cycle.
- Counter widths:
  - Tick count: 5 bits.
  - Bit count: ceil(log2(DBIT)) bits, minimum 1.
  - No wrap-around is reachable in legal operation.
- Data written into the FIFO while a frame is in progress does not affect the current frame. It is picked up on the next IDLE visit.

Test Plan (DVSR=4, DBIT=8, SB_TICK=16 unless stated; bit time 64 clocks, frame 640 clocks):
- Reset with FIFO empty:
  - Required: tx=1, busy=0, fifo_rd=0, tx_done_tick=0.
  - Hold 2000 clocks with fifo_empty=1: tx stays 1 and fifo_rd never pulses.
- Single word 0xA5 (FIFO non-empty from cycle T):
  - fifo_rd is high in cycle T only.
  - tx is 0 for clocks T+1..T+64, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then 1 for 64 clocks.
  - tx_done_tick is high in cycle T+640. busy is high T+1..T+640.
- Back-to-back 0x00 then 0xFF:
  - fifo_rd pulses in cycles T and T+641.
  - tx is high only in cycle T+641 between the two frames.
  - Second frame data bits are all 1.
- Reset during DATA bit 3:
  - tx=1 and busy=0 in the same cycle reset asserts.
  - After release with the FIFO holding 0x3C, a new full frame starts: 64-clock start bit, then bits 0,0,1,1,1,1,0,0.
  - The aborted word is never retransmitted.
- SB_TICK=32, word 0x81:
  - Stop-high interval is 128 clocks.
  - tx_done_tick is high in cycle T+704; next fifo_rd no earlier than T+705.
- FIFO refilled during a frame:
  - A word written mid-frame is not popped until the FSM returns to IDLE.
  - Exactly one fifo_rd pulse per frame.
